// File: rtl/game_state_ctrl.sv
// FlappyBird game sequencer: button synchronise/debounce plus IDLE/PLAY/PAUSE/DEAD control with BCD scoring.
// Define GAME_CTRL_HISCORE_EN to keep a best-score register; otherwise best is tied to 0x00.
module game_state_ctrl #(
  parameter int DEBOUNCE_MS  = 10,
  parameter int DEAD_HOLD_MS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_ms,
  input  logic       start_button,
  input  logic       pause_button,
  input  logic       up_button,
  input  logic       isDead,
  input  logic       pipe_pass,
  output logic [1:0] state,
  output logic       flap,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic       restart_ok
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(DEAD_HOLD_MS + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DEAD_HOLD_MS - 1);

  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_UP    = 2;

  logic       ms_meta_q, ms_sync_q, ms_prev_q, ms_tick_q;
  logic [2:0] btn_raw;
  logic [2:0] btn_meta_q, btn_sync_q;
  logic [2:0] btn_acc_q, btn_acc_d;
  logic [2:0] press;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  logic [1:0]        state_q, state_d;
  logic              flap_q, flap_d;
  logic [7:0]        score_q, score_d, score_inc;
  logic              restart_ok_q, restart_ok_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign btn_raw = {up_button, pause_button, start_button};

  // The ms tick is a registered rising-edge detect, so it lands 3 clk after clk_ms rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_meta_q  <= 1'b0;
      ms_sync_q  <= 1'b0;
      ms_prev_q  <= 1'b0;
      ms_tick_q  <= 1'b0;
      btn_meta_q <= 3'b000;
      btn_sync_q <= 3'b000;
    end else begin
      ms_meta_q  <= clk_ms;
      ms_sync_q  <= ms_meta_q;
      ms_prev_q  <= ms_sync_q;
      ms_tick_q  <= ms_sync_q & ~ms_prev_q;
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
    end
  end

  // A press is the accept event itself, so the FSM reacts on the same edge the level flips.
  always_comb begin
    btn_acc_d = btn_acc_q;
    press     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (ms_tick_q) begin
        if (btn_sync_q[i] == btn_acc_q[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_d[i]  = '0;
          btn_acc_d[i] = btn_sync_q[i];
          press[i]     = btn_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_acc_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      btn_acc_q <= btn_acc_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  always_comb begin
    if (score_q == 8'h99) begin
      score_inc = score_q;
    end else if (score_q[3:0] == 4'h9) begin
      score_inc = {score_q[7:4] + 4'h1, 4'h0};
    end else begin
      score_inc = {score_q[7:4], score_q[3:0] + 4'h1};
    end
  end

  always_comb begin
    state_d      = state_q;
    flap_d       = 1'b0;
    score_d      = score_q;
    restart_ok_d = restart_ok_q;
    hold_d       = hold_q;
    case (state_q)
      ST_IDLE: begin
        score_d      = 8'h00;
        restart_ok_d = 1'b0;
        if (press[BTN_START] || press[BTN_UP]) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (isDead) begin
          state_d      = ST_DEAD;
          hold_d       = '0;
          restart_ok_d = 1'b0;
        end else if (press[BTN_PAUSE]) begin
          state_d = ST_PAUSE;
        end else begin
          flap_d = press[BTN_UP];
          if (pipe_pass) begin
            score_d = score_inc;
          end
        end
      end
      ST_PAUSE: begin
        if (press[BTN_START]) begin
          state_d = ST_IDLE;
          score_d = 8'h00;
        end else if (press[BTN_PAUSE]) begin
          state_d = ST_PLAY;
        end
      end
      ST_DEAD: begin
        if (!restart_ok_q && ms_tick_q) begin
          if (hold_q == HOLD_LAST) begin
            restart_ok_d = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        if (press[BTN_START] && restart_ok_q) begin
          state_d      = ST_IDLE;
          score_d      = 8'h00;
          restart_ok_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        score_d      = 8'h00;
        restart_ok_d = 1'b0;
        hold_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flap_q       <= 1'b0;
      score_q      <= 8'h00;
      restart_ok_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      flap_q       <= flap_d;
      score_q      <= score_d;
      restart_ok_q <= restart_ok_d;
      hold_q       <= hold_d;
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic       enter_dead;
  logic [7:0] best_q, best_d;

  // Valid BCD orders the same as binary, so a plain compare works; score_q excludes the death-cycle pipe.
  assign enter_dead = (state_q == ST_PLAY) && isDead;

  always_comb begin
    best_d = best_q;
    if (enter_dead && (score_q > best_q)) begin
      best_d = score_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= 8'h00;
    end else begin
      best_q <= best_d;
    end
  end

  assign best = best_q;
`else
  assign best = 8'h00;
`endif

  assign state      = state_q;
  assign flap       = flap_q;
  assign score      = score_q;
  assign restart_ok = restart_ok_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: debounce, scoring, pause, death priority, hold time and async reset.
// Expected best values follow GAME_CTRL_HISCORE_EN as defined for the build.
module tb_game_state_ctrl;

  localparam int KIND_START = 0;
  localparam int KIND_PAUSE = 1;
  localparam int KIND_UP    = 2;
  localparam int KIND_PIPE  = 3;
  localparam int KIND_DEATH = 4;

`ifdef GAME_CTRL_HISCORE_EN
  localparam logic [7:0] EXP_BEST_A = 8'h05;
  localparam logic [7:0] EXP_BEST_B = 8'h07;
`else
  localparam logic [7:0] EXP_BEST_A = 8'h00;
  localparam logic [7:0] EXP_BEST_B = 8'h00;
`endif

  logic       clk;
  logic       rst_n;
  logic       clk_ms;
  logic       start_button;
  logic       pause_button;
  logic       up_button;
  logic       isDead;
  logic       pipe_pass;
  logic [1:0] state;
  logic       flap;
  logic [7:0] score;
  logic [7:0] best;
  logic       restart_ok;

  int total;
  int bad;
  int flapCount;
  int msRises;
  int deathRise;

  game_state_ctrl #(
    .DEBOUNCE_MS (10),
    .DEAD_HOLD_MS(1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_ms      (clk_ms),
    .start_button(start_button),
    .pause_button(pause_button),
    .up_button   (up_button),
    .isDead      (isDead),
    .pipe_pass   (pipe_pass),
    .state       (state),
    .flap        (flap),
    .score       (score),
    .best        (best),
    .restart_ok  (restart_ok)
  );

  // 100 MHz-style clk with a 1 ms stand-in of 8 clk; clk_ms edges sit between clk edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_ms = 1'b0;
    #12;
    forever #40 clk_ms = ~clk_ms;
  end

  always @(posedge clk_ms) msRises++;

  always @(posedge clk) begin
    if (flap === 1'b1) flapCount++;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Button kinds hold the level for 10 ms ticks then release for 10 more, so each is one clean press.
  task automatic applyStimulus(input int kind);
    case (kind)
      KIND_START, KIND_PAUSE, KIND_UP: begin
        @(posedge clk_ms);
        if (kind == KIND_START) start_button = 1'b1;
        if (kind == KIND_PAUSE) pause_button = 1'b1;
        if (kind == KIND_UP)    up_button    = 1'b1;
        repeat (10) @(posedge clk_ms);
        start_button = 1'b0;
        pause_button = 1'b0;
        up_button    = 1'b0;
        repeat (10) @(posedge clk_ms);
        #1;
      end
      KIND_PIPE: begin
        @(posedge clk);
        #1 pipe_pass = 1'b1;
        @(posedge clk);
        #1 pipe_pass = 1'b0;
      end
      KIND_DEATH: begin
        @(posedge clk);
        #1;
        isDead    = 1'b1;
        pipe_pass = 1'b1;
        @(posedge clk);
        #1;
        isDead    = 1'b0;
        pipe_pass = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    flapCount    = 0;
    msRises      = 0;
    deathRise    = 0;
    rst_n        = 1'b0;
    start_button = 1'b0;
    pause_button = 1'b0;
    up_button    = 1'b0;
    isDead       = 1'b0;
    pipe_pass    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {6'd0, state}, 8'h00);
    checkOutput("reset_flap", {7'd0, flap}, 8'h00);
    checkOutput("reset_score", score, 8'h00);
    checkOutput("reset_best", best, 8'h00);
    checkOutput("reset_restart_ok", {7'd0, restart_ok}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Glitch of 5 ticks must not be accepted.
    @(posedge clk_ms);
    start_button = 1'b1;
    repeat (5) @(posedge clk_ms);
    start_button = 1'b0;
    repeat (3) @(posedge clk_ms);
    #1;
    checkOutput("glitch_no_start", {6'd0, state}, 8'h00);

    // Held press: state flips exactly one clk after the 10th tick (tick = rise + 3 clk).
    @(posedge clk_ms);
    start_button = 1'b1;
    repeat (9) @(posedge clk_ms);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("debounce_before_10th", {6'd0, state}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("debounce_play", {6'd0, state}, 8'h01);
    @(posedge clk_ms);
    start_button = 1'b0;
    repeat (11) @(posedge clk_ms);
    checkOutput("start_no_flap", flapCount[7:0], 8'h00);

    for (int i = 0; i < 12; i++) applyStimulus(KIND_PIPE);
    checkOutput("score_12", score, 8'h12);
    for (int i = 0; i < 100; i++) applyStimulus(KIND_PIPE);
    checkOutput("score_saturate", score, 8'h99);

    applyStimulus(KIND_PAUSE);
    checkOutput("pause_enter", {6'd0, state}, 8'h02);
    isDead = 1'b1;
    applyStimulus(KIND_PIPE);
    applyStimulus(KIND_UP);
    isDead = 1'b0;
    checkOutput("paused_state", {6'd0, state}, 8'h02);
    checkOutput("paused_score", score, 8'h99);
    checkOutput("paused_no_flap", flapCount[7:0], 8'h00);
    applyStimulus(KIND_PAUSE);
    checkOutput("unpause", {6'd0, state}, 8'h01);

    applyStimulus(KIND_PAUSE);
    applyStimulus(KIND_START);
    checkOutput("abort_state", {6'd0, state}, 8'h00);
    checkOutput("abort_score", score, 8'h00);

    applyStimulus(KIND_UP);
    checkOutput("up_starts_play", {6'd0, state}, 8'h01);
    checkOutput("up_start_no_flap", flapCount[7:0], 8'h00);
    applyStimulus(KIND_UP);
    checkOutput("flap_one_cycle", flapCount[7:0], 8'h01);

    for (int i = 0; i < 5; i++) applyStimulus(KIND_PIPE);
    checkOutput("score_05", score, 8'h05);
    applyStimulus(KIND_DEATH);
    deathRise = msRises;
    checkOutput("death_state", {6'd0, state}, 8'h03);
    checkOutput("death_score", score, 8'h05);
    @(posedge clk);
    #1;
    checkOutput("death_best", best, EXP_BEST_A);
    checkOutput("death_restart_ok", {7'd0, restart_ok}, 8'h00);

    // Early start press lands around hold tick 500 and must be dropped.
    while (msRises - deathRise < 488) @(posedge clk_ms);
    applyStimulus(KIND_START);
    checkOutput("early_start_ignored", {6'd0, state}, 8'h03);
    checkOutput("early_restart_ok", {7'd0, restart_ok}, 8'h00);
    while (msRises - deathRise < 990) @(posedge clk_ms);
    #1;
    checkOutput("hold_not_expired", {7'd0, restart_ok}, 8'h00);
    while (msRises - deathRise < 1003) @(posedge clk_ms);
    #1;
    checkOutput("hold_expired", {7'd0, restart_ok}, 8'h01);
    checkOutput("hold_still_dead", {6'd0, state}, 8'h03);
    applyStimulus(KIND_START);
    checkOutput("restart_state", {6'd0, state}, 8'h00);
    checkOutput("restart_score", score, 8'h00);
    checkOutput("restart_best_kept", best, EXP_BEST_A);

    applyStimulus(KIND_START);
    for (int i = 0; i < 7; i++) applyStimulus(KIND_PIPE);
    applyStimulus(KIND_DEATH);
    @(posedge clk);
    #1;
    checkOutput("game2_dead", {6'd0, state}, 8'h03);
    checkOutput("game2_score", score, 8'h07);
    checkOutput("game2_best", best, EXP_BEST_B);

    // Reset asserted mid-cycle; outputs must clear before the next clk edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_state", {6'd0, state}, 8'h00);
    checkOutput("async_score", score, 8'h00);
    checkOutput("async_best", best, 8'h00);
    checkOutput("async_restart_ok", {7'd0, restart_ok}, 8'h00);
    #20 rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
